multicycle_control: RTL and testbench
=====================================

# multicycle_control

- Moore-style finite-state controller that sequences the 16-bit TSC multi-cycle datapath through IF/ID/EX/MEM/WB.
- Drives the shared ALU, PC, IR, register file and the single unified memory port.
- `AluOp` uses the existing 3-bit AluOp encoding so the existing `ALU_CONTROL` decoder is reused unchanged.
- Sits between the IR/ALU-flag outputs and every datapath enable/mux select.

## Interface
- `WORD_SIZE`, 16, width of `num_inst`.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 4: IR[15:12].
- `funct` in 6: IR[5:0].
- `bcond` in 1: ALU branch-condition flag.
- `inputReady` in 1: memory completion ack.
- `readM`, `writeM` out 1: memory read/write request.
- `IorD` out 1: address select, 0=PC, 1=ALUOut.
- `IRWrite` out 1: latch IR.
- `PCWrite` out 1: update PC.
- `PCSrc` out 2: PC source, 0=ALU result, 1=ALUOut, 2=jump target, 3=rs.
- `RegWrite` out 1: register-file write enable.
- `RegDest` out 2: write register, 0=rt, 1=rd, 2=r2.
- `WriteDataSel` out 2: write data, 0=ALUOut, 1=MDR, 2=PC.
- `AluSrcA` out 1: ALU A operand, 0=PC, 1=rs.
- `AluSrcB` out 2: ALU B operand, 0=rt, 1=const 1, 2=sign-extended immediate.
- `AluOp` out 3: 0=funct, 1=ADD, 2=OR, 3=LHI, 4..7=BNE/BEQ/BGZ/BLZ.
- `OutWrite` out 1: WWD output strobe.
- `is_halted` out 1: high once HLT retires.
- `num_inst` out WORD_SIZE: retired-instruction count.

## Operation
States are IF, ID, EX, MEM, WB, HALT. All outputs not listed for a state are 0.

- **IF**
  - Outputs: `readM`=1, `IorD`=0, `AluSrcA`=0, `AluSrcB`=1, `AluOp`=1.
  - `IRWrite`=`PCWrite`=`inputReady`, with `PCSrc`=0.
  - Stay in IF until `inputReady`=1, then go to ID.
- **ID**
  - Outputs: `AluSrcA`=0, `AluSrcB`=2, `AluOp`=1 (branch target into ALUOut).
  - JMP (9): `PCWrite`=1, `PCSrc`=2, then IF.
  - JAL (10): JMP outputs plus `RegWrite`=1, `RegDest`=2, `WriteDataSel`=2, then IF.
  - JPR (15/25): `PCWrite`=1, `PCSrc`=3, then IF.
  - JRL (15/26): JPR outputs plus the JAL link write, then IF.
  - HLT (15/29): go to HALT.
  - Opcodes 11–14 and undefined R funct: NOP, go to IF.
  - All other opcodes: go to EX.
- **EX**
  - Branch (0–3): `AluSrcA`=1, `AluSrcB`=0, `AluOp`=4+opcode; `PCWrite`=`bcond`, `PCSrc`=1; then IF.
  - WWD (15/28): `OutWrite`=1, then IF.
  - R-type ALU (funct 0–7): `AluSrcA`=1, `AluSrcB`=0, `AluOp`=0; then WB.
  - ADI, LWD, SWD: `AluSrcA`=1, `AluSrcB`=2, `AluOp`=1. ADI goes to WB; LWD and SWD go to MEM.
  - ORI: same as ADI but `AluOp`=2; then WB.
  - LHI: same as ADI but `AluOp`=3; then WB.
- **MEM**
  - Outputs: `IorD`=1; `readM`=1 for LWD, `writeM`=1 for SWD.
  - Hold until `inputReady`=1, then LWD goes to WB and SWD goes to IF.
- **WB**
  - Outputs: `RegWrite`=1.
  - `RegDest`=1 for R-type, 0 otherwise.
  - `WriteDataSel`=1 for LWD, 0 otherwise.
  - Then IF.
- **HALT**
  - `is_halted`=1, all other outputs 0.
  - Sticky: only reset exits.

Retirement counting:
- `num_inst` increments by 1 on every clock edge where the state transitions into IF or into HALT.
- It wraps from 16'hFFFF to 0.

## Timing
- **Reset:** while `reset_n`=0, state=IF (registered, asynchronous), `num_inst`=0, `is_halted`=0, and every output is forced to 0, including `readM`. `readM` rises combinationally once `reset_n` goes high.
- **Outputs:** combinational decode of registered state, `opcode`, `funct`, `bcond` and `inputReady`. The only registered outputs are `num_inst` and `is_halted`. `opcode`/`funct` are ignored in IF (the IR is stale).
- **Memory handshake:** the request is held until `inputReady` is sampled high at a rising edge. The request deasserts in the following state. `inputReady` outside IF/MEM is ignored.
- **Latency with a 1-cycle memory:**
  - JMP/JAL/JPR/JRL/NOP: 2 cycles.
  - Branch/WWD: 3 cycles.
  - R-type/ADI/ORI/LHI/SWD: 4 cycles.
  - LWD: 5 cycles.
  - Every extra memory wait cycle adds 1.
- **Reset mid-operation:** the request drops immediately, the in-flight instruction is not counted, and no register or PC write occurs.
- **HLT:** HLT counts as retired.

## Structure
- **Shared package:**
  - State encoding (3-bit).
  - Opcode/funct constants, taken from the existing opcode definitions.
  - AluOp encoding (0–7 as above).
  - PCSrc, RegDest, WriteDataSel, AluSrcB encodings.
- **Sub-module:** `mc_out_decode`, a pure combinational map (state, opcode, funct, bcond, inputReady) → control outputs.
- **Top module:** the top holds the state register, next-state logic, `num_inst` and `is_halted`.

## Test plan
1. **Reset and R-type ADD:** release reset, then ADD (15/0) with 1-cycle memory. Required response:
   - State trace IF→ID→EX→WB→IF.
   - `RegWrite`=1, `RegDest`=1 in WB.
   - `num_inst`=1 after 4 cycles.
2. **LWD with memory waits:** LWD with `inputReady` delayed 3 cycles in MEM. Required response:
   - `readM`=1 and `IorD`=1 held for all 4 MEM cycles.
   - `WriteDataSel`=1 in WB.
   - Total 8 cycles.
3. **BEQ:** BEQ with `bcond`=0, then BEQ with `bcond`=1. Required response:
   - First: `PCWrite`=0 in EX.
   - Second: `PCWrite`=1, `PCSrc`=1, `AluOp`=5.
   - 3 cycles each.
4. **Jumps and output:** JAL, then WWD. Required response:
   - JAL: 2 cycles, `RegDest`=2, `WriteDataSel`=2, `PCSrc`=2.
   - WWD: `OutWrite`=1 for exactly 1 cycle, `RegWrite`=0.
5. **HLT:** HLT, then toggle `inputReady` for 10 cycles. Required response:
   - `is_halted`=1 and remains 1.
   - All other outputs stay 0.
   - `num_inst` does not change further.
6. **Reset and counter wrap:** assert `reset_n`=0 mid-MEM of SWD. Required response:
   - `writeM`=0 immediately; state=IF; `num_inst`=0.
   - Separately, preload 16'hFFFF retirements; the next retire gives 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the TSC multi-cycle controller: FSM states, opcode/funct
// values, datapath select encodings and the bundled control-output struct.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [2:0] ALU_FUNCT = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_LHI   = 3'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_R2 = 2'd2;

  localparam logic [1:0] WD_ALUOUT = 2'd0;
  localparam logic [1:0] WD_MDR    = 2'd1;
  localparam logic [1:0] WD_PC     = 2'd2;

  localparam logic [1:0] SRCB_RT  = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  typedef struct packed {
    logic       read_m;
    logic       write_m;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dest;
    logic [1:0] write_data_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       out_write;
  } ctl_t;

  // R-type functs 0..7 are plain ALU operations that write back rd.
  function automatic logic is_alu_funct(input logic [5:0] f);
    return f <= FN_SHR;
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Moore output decode: maps the current state (plus IR fields, bcond and the
// memory ack) onto every datapath enable and mux select.
module mc_out_decode
  import multicycle_control_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic [5:0] funct,
  input  logic       bcond,
  input  logic       input_ready,
  output ctl_t       ctl
);

  always_comb begin
    ctl = '0;
    case (state)
      S_IF: begin
        ctl.read_m    = 1'b1;
        ctl.alu_src_b = SRCB_ONE;
        ctl.alu_op    = ALU_ADD;
        ctl.ir_write  = input_ready;
        ctl.pc_write  = input_ready;
        ctl.pc_src    = PC_ALU;
      end
      S_ID: begin
        // Branch target is computed here so EX can use ALUOut as PC source.
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
        if (opcode == OP_JMP || opcode == OP_JAL) begin
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PC_JUMP;
        end
        if (opcode == OP_RTYPE && (funct == FN_JPR || funct == FN_JRL)) begin
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PC_RS;
        end
        if (opcode == OP_JAL || (opcode == OP_RTYPE && funct == FN_JRL)) begin
          ctl.reg_write      = 1'b1;
          ctl.reg_dest       = RD_R2;
          ctl.write_data_sel = WD_PC;
        end
      end
      S_EX: begin
        case (opcode)
          OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_RT;
            ctl.alu_op    = {1'b1, opcode[1:0]};
            ctl.pc_write  = bcond;
            ctl.pc_src    = PC_ALUOUT;
          end
          OP_ADI, OP_LWD, OP_SWD, OP_ORI, OP_LHI: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_IMM;
            ctl.alu_op    = (opcode == OP_ORI) ? ALU_OR :
                            (opcode == OP_LHI) ? ALU_LHI : ALU_ADD;
          end
          OP_RTYPE: begin
            if (funct == FN_WWD) begin
              ctl.out_write = 1'b1;
            end else if (is_alu_funct(funct)) begin
              ctl.alu_src_a = 1'b1;
              ctl.alu_src_b = SRCB_RT;
              ctl.alu_op    = ALU_FUNCT;
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctl.i_or_d  = 1'b1;
        ctl.read_m  = (opcode == OP_LWD);
        ctl.write_m = (opcode == OP_SWD);
      end
      S_WB: begin
        ctl.reg_write      = 1'b1;
        ctl.reg_dest       = (opcode == OP_RTYPE) ? RD_RD : RD_RT;
        ctl.write_data_sel = (opcode == OP_LWD) ? WD_MDR : WD_ALUOUT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// TSC multi-cycle controller top: state register, next-state logic, retirement
// counter and halt flag; outputs come from mc_out_decode, forced low in reset.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 bcond,
  input  logic                 inputReady,
  output logic                 readM,
  output logic                 writeM,
  output logic                 IorD,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic [1:0]           PCSrc,
  output logic                 RegWrite,
  output logic [1:0]           RegDest,
  output logic [1:0]           WriteDataSel,
  output logic                 AluSrcA,
  output logic [1:0]           AluSrcB,
  output logic [2:0]           AluOp,
  output logic                 OutWrite,
  output logic                 is_halted,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic [2:0]           state
);

  state_t cur_state;
  state_t next_state;
  ctl_t   ctl_raw;
  ctl_t   ctl;
  logic   retire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur_state <= S_IF;
    else          cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_IF: if (inputReady) next_state = S_ID;
      S_ID: begin
        if (opcode == OP_JMP || opcode == OP_JAL) begin
          next_state = S_IF;
        end else if (opcode == OP_RTYPE) begin
          if (funct == FN_HLT)
            next_state = S_HALT;
          else if (is_alu_funct(funct) || funct == FN_WWD)
            next_state = S_EX;
          else
            next_state = S_IF;  // JPR, JRL and undefined functs finish here
        end else if (opcode > OP_JAL) begin
          next_state = S_IF;    // opcodes 11-14 are NOPs
        end else begin
          next_state = S_EX;
        end
      end
      S_EX: begin
        if (opcode == OP_LWD || opcode == OP_SWD)
          next_state = S_MEM;
        else if (opcode == OP_ADI || opcode == OP_ORI || opcode == OP_LHI ||
                 (opcode == OP_RTYPE && is_alu_funct(funct)))
          next_state = S_WB;
        else
          next_state = S_IF;
      end
      S_MEM:   if (inputReady) next_state = (opcode == OP_LWD) ? S_WB : S_IF;
      S_WB:    next_state = S_IF;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IF;
    endcase
  end

  mc_out_decode u_out_decode (
    .state       (cur_state),
    .opcode      (opcode),
    .funct       (funct),
    .bcond       (bcond),
    .input_ready (inputReady),
    .ctl         (ctl_raw)
  );

  // Reset must silence the memory request even though the state reads as IF.
  always_comb begin
    ctl = reset_n ? ctl_raw : '0;
  end

  assign readM        = ctl.read_m;
  assign writeM       = ctl.write_m;
  assign IorD         = ctl.i_or_d;
  assign IRWrite      = ctl.ir_write;
  assign PCWrite      = ctl.pc_write;
  assign PCSrc        = ctl.pc_src;
  assign RegWrite     = ctl.reg_write;
  assign RegDest      = ctl.reg_dest;
  assign WriteDataSel = ctl.write_data_sel;
  assign AluSrcA      = ctl.alu_src_a;
  assign AluSrcB      = ctl.alu_src_b;
  assign AluOp        = ctl.alu_op;
  assign OutWrite     = ctl.out_write;
  assign state        = cur_state;

  assign retire = ((next_state == S_IF)   && (cur_state != S_IF)) ||
                  ((next_state == S_HALT) && (cur_state != S_HALT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_inst  <= '0;
      is_halted <= 1'b0;
    end else begin
      if (retire) num_inst <= num_inst + WORD_SIZE'(1);
      is_halted <= (next_state == S_HALT);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: hand-written per-cycle state and
// control expectations, plus a narrow-counter instance to exercise the wrap.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [3:0] opcode;
  logic [5:0] funct;
  logic       bcond;
  logic       input_ready;

  logic        readM, writeM, IorD, IRWrite, PCWrite, RegWrite, AluSrcA, OutWrite, is_halted;
  logic [1:0]  PCSrc, RegDest, WriteDataSel, AluSrcB;
  logic [2:0]  AluOp, state;
  logic [15:0] num_inst;

  logic       w_rm, w_wm, w_iord, w_irw, w_pcw, w_rw, w_a, w_ow, w_halt;
  logic [1:0] w_pcs, w_rd, w_wds, w_b;
  logic [2:0] w_op, w_state, w_num;

  multicycle_control #(.WORD_SIZE(16)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .bcond(bcond),
    .inputReady(input_ready), .readM(readM), .writeM(writeM), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .RegDest(RegDest), .WriteDataSel(WriteDataSel), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .AluOp(AluOp), .OutWrite(OutWrite), .is_halted(is_halted),
    .num_inst(num_inst), .state(state)
  );

  // 3-bit counter copy: wraps after 8 retirements
  multicycle_control #(.WORD_SIZE(3)) dut_w (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .bcond(bcond),
    .inputReady(input_ready), .readM(w_rm), .writeM(w_wm), .IorD(w_iord),
    .IRWrite(w_irw), .PCWrite(w_pcw), .PCSrc(w_pcs), .RegWrite(w_rw),
    .RegDest(w_rd), .WriteDataSel(w_wds), .AluSrcA(w_a), .AluSrcB(w_b),
    .AluOp(w_op), .OutWrite(w_ow), .is_halted(w_halt), .num_inst(w_num),
    .state(w_state)
  );

  logic [18:0] ctl;
  assign ctl = {readM, writeM, IorD, IRWrite, PCWrite, PCSrc, RegWrite, RegDest,
                WriteDataSel, AluSrcA, AluSrcB, AluOp, OutWrite};

  function automatic logic [18:0] mk(input int rm, wm, iord, irw, pcw, pcs, rw, rd,
                                     wds, a, b, op, ow);
    return {1'(rm), 1'(wm), 1'(iord), 1'(irw), 1'(pcw), 2'(pcs), 1'(rw), 2'(rd),
            2'(wds), 1'(a), 2'(b), 3'(op), 1'(ow)};
  endfunction

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  int exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: sample one cycle at the falling edge, then step past the next rise
  task automatic cyc(input string tag, input logic [18:0] exp_ctl);
    logic [2:0] es;
    @(negedge clk);
    es = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b111;
    check({tag, "_state"}, 32'(state), 32'(es));
    check({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [3:0] op, input logic [5:0] fn, input logic bc);
    opcode = op;
    funct  = fn;
    bcond  = bc;
  endtask

  task automatic retired(input string tag);
    exp_cnt++;
    check({tag, "_cnt"}, 32'(num_inst), 32'(exp_cnt));
  endtask

  logic [18:0] c_if_wait, c_if_ack, c_id, c_ex_r, c_ex_imm, c_wb_r, c_wb_i, c_wb_ld;
  logic [18:0] c_mem_rd, c_mem_wr, c_jmp, c_jal, c_jrl;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rm wm io irw pcw pcs rw rd wds a b op ow
    c_if_wait = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    c_if_ack  = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    c_id      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
    c_ex_r    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    c_ex_imm  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0);
    c_wb_r    = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    c_wb_i    = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    c_wb_ld   = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    c_mem_rd  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    c_mem_wr  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    c_jmp     = mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 2, 1, 0);
    c_jal     = mk(0, 0, 0, 0, 1, 2, 1, 2, 2, 0, 2, 1, 0);
    c_jrl     = mk(0, 0, 0, 0, 1, 3, 1, 2, 2, 0, 2, 1, 0);

    reset_n = 1'b0;
    input_ready = 1'b0;
    set_inst(4'd0, 6'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'(S_IF));
    check("rst_ctl", 32'(ctl), 32'd0);
    check("rst_cnt", 32'(num_inst), 32'd0);
    check("rst_halt", 32'(is_halted), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("rel_readm", 32'(readM), 32'd1);

    // ADD with 1-cycle memory, preceded by one IF wait cycle
    exp_q.push_back(S_IF);
    cyc("if_wait", c_if_wait);
    set_inst(OP_RTYPE, FN_ADD, 1'b0);
    exp_q = {S_IF, S_ID, S_EX, S_WB};
    input_ready = 1'b1; cyc("add_if", c_if_ack);
    input_ready = 1'b0; cyc("add_id", c_id);
    cyc("add_ex", c_ex_r);
    cyc("add_wb", c_wb_r);
    retired("add");

    // LWD with three MEM wait cycles
    set_inst(OP_LWD, 6'd0, 1'b0);
    exp_q = {S_IF, S_ID, S_EX, S_MEM, S_MEM, S_MEM, S_MEM, S_WB};
    input_ready = 1'b1; cyc("lwd_if", c_if_ack);
    input_ready = 1'b0; cyc("lwd_id", c_id);
    cyc("lwd_ex", c_ex_imm);
    for (int i = 0; i < 3; i++) cyc("lwd_memw", c_mem_rd);
    input_ready = 1'b1; cyc("lwd_mem", c_mem_rd);
    input_ready = 1'b0; cyc("lwd_wb", c_wb_ld);
    retired("lwd");

    // BEQ not taken, BEQ taken, BLZ not taken
    for (int k = 0; k < 3; k++) begin
      logic [3:0] bop;
      bop = (k == 2) ? OP_BLZ : OP_BEQ;
      set_inst(bop, 6'd0, (k == 1));
      exp_q = {S_IF, S_ID, S_EX};
      input_ready = 1'b1; cyc("br_if", c_if_ack);
      input_ready = 1'b0; cyc("br_id", c_id);
      cyc("br_ex", mk(0, 0, 0, 0, (k == 1) ? 1 : 0, 1, 0, 0, 0, 1, 0, (k == 2) ? 7 : 5, 0));
      retired("br");
    end

    // JAL, JRL, WWD, NOP opcode 12
    set_inst(OP_JAL, 6'd0, 1'b0);
    exp_q = {S_IF, S_ID};
    input_ready = 1'b1; cyc("jal_if", c_if_ack);
    input_ready = 1'b0; cyc("jal_id", c_jal);
    retired("jal");
    set_inst(OP_RTYPE, FN_JRL, 1'b0);
    exp_q = {S_IF, S_ID};
    input_ready = 1'b1; cyc("jrl_if", c_if_ack);
    input_ready = 1'b0; cyc("jrl_id", c_jrl);
    retired("jrl");
    set_inst(OP_RTYPE, FN_WWD, 1'b0);
    exp_q = {S_IF, S_ID, S_EX, S_IF};
    input_ready = 1'b1; cyc("wwd_if", c_if_ack);
    input_ready = 1'b0; cyc("wwd_id", c_id);
    cyc("wwd_ex", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    retired("wwd");
    cyc("wwd_after", c_if_wait);
    set_inst(4'd12, 6'd0, 1'b0);
    exp_q = {S_IF, S_ID};
    input_ready = 1'b1; cyc("nop_if", c_if_ack);
    input_ready = 1'b0; cyc("nop_id", c_id);
    retired("nop");

    // ORI and LHI write back rt from ALUOut
    for (int k = 0; k < 2; k++) begin
      set_inst((k == 0) ? OP_ORI : OP_LHI, 6'd0, 1'b0);
      exp_q = {S_IF, S_ID, S_EX, S_WB};
      input_ready = 1'b1; cyc("imm_if", c_if_ack);
      input_ready = 1'b0; cyc("imm_id", c_id);
      cyc("imm_ex", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, (k == 0) ? 2 : 3, 0));
      cyc("imm_wb", c_wb_i);
      retired("imm");
    end

    // SWD with 1-cycle memory
    set_inst(OP_SWD, 6'd0, 1'b0);
    exp_q = {S_IF, S_ID, S_EX, S_MEM};
    input_ready = 1'b1; cyc("swd_if", c_if_ack);
    input_ready = 1'b0; cyc("swd_id", c_id);
    cyc("swd_ex", c_ex_imm);
    input_ready = 1'b1; cyc("swd_mem", c_mem_wr);
    input_ready = 1'b0;
    retired("swd");

    // reset in the middle of an SWD memory wait
    exp_q = {S_IF, S_ID, S_EX};
    input_ready = 1'b1; cyc("swr_if", c_if_ack);
    input_ready = 1'b0; cyc("swr_id", c_id);
    cyc("swr_ex", c_ex_imm);
    check("swr_mem_wm", 32'(writeM), 32'd1);
    reset_n = 1'b0;
    #1;
    check("swr_rst_wm", 32'(writeM), 32'd0);
    check("swr_rst_ctl", 32'(ctl), 32'd0);
    check("swr_rst_state", 32'(state), 32'(S_IF));
    check("swr_rst_cnt", 32'(num_inst), 32'd0);
    exp_cnt = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // nine JMPs: the 3-bit counter wraps 7 -> 0 -> 1
    set_inst(OP_JMP, 6'd0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      exp_q = {S_IF, S_ID};
      input_ready = 1'b1; cyc("jmp_if", c_if_ack);
      input_ready = 1'b0; cyc("jmp_id", c_jmp);
      retired("jmp");
      check("wrap_cnt", 32'(w_num), 32'(k % 8));
    end

    // HLT is sticky and ignores the memory ack
    set_inst(OP_RTYPE, FN_HLT, 1'b0);
    exp_q = {S_IF, S_ID};
    input_ready = 1'b1; cyc("hlt_if", c_if_ack);
    input_ready = 1'b0; cyc("hlt_id", c_id);
    retired("hlt");
    check("hlt_flag", 32'(is_halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      input_ready = i[0];
      exp_q.push_back(S_HALT);
      cyc("halt", 19'd0);
      check("halt_flag", 32'(is_halted), 32'd1);
      check("halt_cnt", 32'(num_inst), 32'(exp_cnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
